// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the RMII packet receiver.
//   rx_state_t      receiver FSM state encoding
//   DIBIT_PRE/SFD   preamble and start-of-frame dibit codes
//   *_BYTES         Ethernet header/frame byte counts
//   CRC_*           CRC-32 polynomial (reflected), init value, good-frame residue
//   BROADCAST_MAC   all-ones destination address
//   bit_reverse32   maps a reflected CRC register to normal bit order
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_HEADER   = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_DROP     = 3'd4
   } rx_state_t;

   localparam logic [1:0] DIBIT_PRE = 2'b01;
   localparam logic [1:0] DIBIT_SFD = 2'b11;

   localparam int MAC_BYTES             = 6;
   localparam int TYPE_BYTES            = 2;
   localparam int HDR_BYTES             = 2 * MAC_BYTES + TYPE_BYTES;
   localparam int PAYLOAD_CAPTURE_BYTES = 4;
   localparam int FCS_BYTES             = 4;
   localparam int MIN_DATA_BYTES        = 60;
   localparam int MIN_FRAME_BYTES       = MIN_DATA_BYTES + FCS_BYTES;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

   localparam logic [47:0] BROADCAST_MAC = 48'hffff_ffff_ffff;

   // The CRC shift register runs LSB-first, so its contents are the
   // bit-mirror of the conventional (MSB-first) residue constant.
   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_crc32.sv
// rx_crc32: dibit-serial Ethernet CRC-32 (reflected 0x04C11DB7).
// Only built when RX_FCS_CHECK_EN is defined.
//   clk    in   clock, posedge
//   rst_n  in   synchronous active-low reset (register -> init value)
//   clr    in   reload init value (start of frame)
//   en     in   absorb din this cycle
//   din    in   2-bit dibit, din[0] is the earlier bit on the wire
//   crc    out  running CRC register, reflected bit order, not inverted
`ifdef RX_FCS_CHECK_EN
module rx_crc32
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [1:0]  din,
   output logic [31:0] crc
);

   logic [31:0] crc_next;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      return {1'b0, c[31:1]} ^ ((c[0] ^ b) ? CRC_POLY_REFL : 32'h0);
   endfunction

   always_comb begin
      crc_next = crc_step(crc_step(crc, din[0]), din[1]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if (clr) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule
`endif

// File: rtl/packet_receiver.sv
// packet_receiver: RMII (LAN8720) receive path.
// Locks on preamble/SFD, filters on destination MAC, captures source MAC,
// EtherType and the first four payload bytes, checks length, alignment and
// (optionally) FCS, then reports one result pulse per frame.
// Optional feature macro: RX_FCS_CHECK_EN (CRC-32 check over the frame).
//   clk        in   RMII REF_CLK, 50 MHz, posedge
//   rst_n      in   synchronous active-low reset
//   rx         in   RXD[1:0], LSB-first dibits
//   rx_dv      in   CRS_DV used as data-valid
//   data       out  payload bytes 0..3, data[7:0] = first payload byte
//   src_mac    out  source MAC, first wire byte in [47:40]
//   ethertype  out  EtherType, first wire byte in [15:8]
//   valid      out  1-cycle pulse: frame accepted, outputs updated same cycle
//   frame_drop out  1-cycle pulse: frame rejected after SFD
//   busy       out  high whenever the FSM is not idle
//
// state       | meaning
// ST_IDLE     | waiting for a preamble dibit (only after rx_dv seen low)
// ST_PREAMBLE | counting 01 dibits, waiting for SFD dibit 11
// ST_HEADER   | bytes 0..13: destination filter, source MAC, EtherType
// ST_PAYLOAD  | byte 14 onward: capture 4 bytes, count the rest
// ST_DROP     | frame rejected, ignore rx until rx_dv falls
module packet_receiver
   import eth_pkg::*;
#(
   parameter logic [47:0] OWN_MAC          = 48'he86a64e7e830,
   parameter bit          ACCEPT_BROADCAST = 1'b1,
   parameter int          MIN_PREAMBLE     = 4,
   parameter int          MAX_FRAME_BYTES  = 1518
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  rx,
   input  logic        rx_dv,
   output logic [31:0] data,
   output logic [47:0] src_mac,
   output logic [15:0] ethertype,
   output logic        valid,
   output logic        frame_drop,
   output logic        busy
);

   localparam int              PRE_W     = $clog2(MIN_PREAMBLE + 2);
   localparam logic [PRE_W-1:0] PRE_MIN  = PRE_W'(MIN_PREAMBLE);
   localparam logic [10:0]     CNT_MAX   = 11'(MAX_FRAME_BYTES);
   localparam logic [10:0]     CNT_SAT   = 11'(MAX_FRAME_BYTES + 1);
   localparam logic [10:0]     CNT_MIN   = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0]     DEST_END  = 11'(MAC_BYTES);
   localparam logic [10:0]     DEST_LAST = 11'(MAC_BYTES - 1);
   localparam logic [10:0]     SRC_END   = 11'(2 * MAC_BYTES);
   localparam logic [10:0]     HDR_END   = 11'(HDR_BYTES);
   localparam logic [10:0]     HDR_LAST  = 11'(HDR_BYTES - 1);
   localparam logic [10:0]     CAP_END   = 11'(HDR_BYTES + PAYLOAD_CAPTURE_BYTES);

   rx_state_t          state;
   rx_state_t          state_next;
   logic               rx_dv_seen_low;
   logic [PRE_W-1:0]   pre_cnt;
   logic [1:0]         dibit_idx;
   logic [5:0]         byte_sr;
   logic [10:0]        byte_cnt;
   logic               own_match;
   logic               bc_match;
   logic [47:0]        src_sh;
   logic [15:0]        type_sh;
   logic [31:0]        data_sh;

   logic               in_frame;
   logic               byte_done;
   logic [7:0]         byte_val;
   logic [7:0]         own_byte;
   logic [10:0]        cnt_inc;
   logic               own_ok_next;
   logic               bc_ok_next;
   logic               dest_fail;
   logic               len_fail;
   logic               fcs_ok;
   logic               frame_ok;
   logic               sfd_det;
   logic               accept_pulse;
   logic               drop_pulse;

   assign busy = (state != ST_IDLE);

   // ------------------------------------------------------------------
   // Byte assembly and per-byte checks
   // ------------------------------------------------------------------
   assign in_frame  = (state == ST_HEADER) || (state == ST_PAYLOAD);
   assign byte_done = in_frame && rx_dv && (dibit_idx == 2'd3);
   // Dibits 0..2 sit in byte_sr; the current rx completes the byte.
   assign byte_val  = {rx, byte_sr};
   assign cnt_inc   = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 11'd1;

   always_comb begin
      own_byte = 8'h00;
      case (byte_cnt[2:0])
         3'd0:    own_byte = OWN_MAC[47:40];
         3'd1:    own_byte = OWN_MAC[39:32];
         3'd2:    own_byte = OWN_MAC[31:24];
         3'd3:    own_byte = OWN_MAC[23:16];
         3'd4:    own_byte = OWN_MAC[15:8];
         3'd5:    own_byte = OWN_MAC[7:0];
         default: own_byte = 8'h00;
      endcase
   end

   assign own_ok_next = own_match && (byte_val == own_byte);
   assign bc_ok_next  = bc_match && (byte_val == BROADCAST_MAC[7:0]);
   assign dest_fail   = byte_done && (byte_cnt == DEST_LAST) && !own_ok_next && !bc_ok_next;
   assign len_fail    = byte_done && (cnt_inc > CNT_MAX);

`ifdef RX_FCS_CHECK_EN
   logic [31:0] crc;

   rx_crc32 u_rx_crc32 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sfd_det),
      .en    (in_frame && rx_dv),
      .din   (rx),
      .crc   (crc)
   );

   assign fcs_ok = (bit_reverse32(crc) == CRC_RESIDUE);
`else
   assign fcs_ok = 1'b1;
`endif

   assign frame_ok = (dibit_idx == 2'd0) && (byte_cnt >= CNT_MIN) && fcs_ok;

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      sfd_det      = 1'b0;
      accept_pulse = 1'b0;
      drop_pulse   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_dv && (rx == DIBIT_PRE) && rx_dv_seen_low) begin
               state_next = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (!rx_dv) begin
               state_next = ST_IDLE;
            end else if (rx == DIBIT_PRE) begin
               state_next = ST_PREAMBLE;
            end else if ((rx == DIBIT_SFD) && (pre_cnt >= PRE_MIN)) begin
               state_next = ST_HEADER;
               sfd_det    = 1'b1;
            end else begin
               state_next = ST_DROP;
            end
         end
         ST_HEADER, ST_PAYLOAD: begin
            if (!rx_dv) begin
               state_next   = ST_IDLE;
               accept_pulse = frame_ok;
               drop_pulse   = !frame_ok;
            end else if (dest_fail || len_fail) begin
               state_next = ST_DROP;
               drop_pulse = 1'b1;
            end else if ((state == ST_HEADER) && byte_done && (byte_cnt == HDR_LAST)) begin
               state_next = ST_PAYLOAD;
            end
         end
         ST_DROP: begin
            if (!rx_dv) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State, counters, shadow and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         rx_dv_seen_low <= 1'b0;
         pre_cnt        <= '0;
         dibit_idx      <= 2'd0;
         byte_sr        <= 6'd0;
         byte_cnt       <= 11'd0;
         own_match      <= 1'b0;
         bc_match       <= 1'b0;
         src_sh         <= 48'd0;
         type_sh        <= 16'd0;
         data_sh        <= 32'd0;
         data           <= 32'd0;
         src_mac        <= 48'd0;
         ethertype      <= 16'd0;
         valid          <= 1'b0;
         frame_drop     <= 1'b0;
      end else begin
         state      <= state_next;
         valid      <= accept_pulse;
         frame_drop <= drop_pulse;

         if (!rx_dv) begin
            rx_dv_seen_low <= 1'b1;
         end

         // The dibit that moves IDLE -> PREAMBLE is the first preamble dibit.
         if (state == ST_IDLE) begin
            pre_cnt <= PRE_W'(1);
         end else if ((state == ST_PREAMBLE) && rx_dv && (rx == DIBIT_PRE) && (pre_cnt < PRE_MIN)) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end

         if (sfd_det) begin
            dibit_idx <= 2'd0;
            byte_cnt  <= 11'd0;
            own_match <= 1'b1;
            bc_match  <= ACCEPT_BROADCAST;
         end else if (in_frame && rx_dv) begin
            dibit_idx <= dibit_idx + 2'd1;
            byte_sr   <= {rx, byte_sr[5:2]};
            if (byte_done) begin
               byte_cnt <= cnt_inc;
               if (byte_cnt < DEST_END) begin
                  own_match <= own_ok_next;
                  bc_match  <= bc_ok_next;
               end else if (byte_cnt < SRC_END) begin
                  src_sh <= {src_sh[39:0], byte_val};
               end else if (byte_cnt < HDR_END) begin
                  type_sh <= {type_sh[7:0], byte_val};
               end else if (byte_cnt < CAP_END) begin
                  data_sh <= {byte_val, data_sh[31:8]};
               end
            end
         end

         if (accept_pulse) begin
            data      <= data_sh;
            src_mac   <= src_sh;
            ethertype <= type_sh;
         end
      end
   end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: directed bench for packet_receiver with a result scoreboard.
module tb_packet_receiver;
   logic        clk;
   logic        rst_n;
   logic [1:0]  rx;
   logic        rx_dv;
   logic [31:0] data;
   logic [47:0] src_mac;
   logic [15:0] ethertype;
   logic        valid;
   logic        frame_drop;
   logic        busy;

   localparam logic [47:0] OWN   = 48'he86a64e7e830;
   localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
   localparam logic [47:0] OTHER = 48'h0200_0000_0001;

   packet_receiver dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .rx_dv      (rx_dv),
      .data       (data),
      .src_mac    (src_mac),
      .ethertype  (ethertype),
      .valid      (valid),
      .frame_drop (frame_drop),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic        is_drop;
      logic [31:0] d;
      logic [47:0] s;
      logic [15:0] t;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  tx_bytes[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_data   = 32'd0;
   logic [47:0] m_src    = 48'd0;
   logic [15:0] m_type   = 16'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_accept(input logic [31:0] d, input logic [47:0] s, input logic [15:0] t);
      exp_t e;
      e.is_drop = 1'b0; e.d = d; e.s = s; e.t = t;
      sb.push_back(e);
      m_data = d; m_src = s; m_type = t;
   endtask

   task automatic push_drop();
      exp_t e;
      e.is_drop = 1'b1; e.d = m_data; e.s = m_src; e.t = m_type;
      sb.push_back(e);
   endtask

   task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input logic [31:0] pay, input int total);
      logic [31:0] crc;
      tx_bytes.delete();
      for (int i = 5; i >= 0; i--) tx_bytes.push_back(dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) tx_bytes.push_back(src[8*i +: 8]);
      tx_bytes.push_back(typ[15:8]);
      tx_bytes.push_back(typ[7:0]);
      for (int i = 0; i < 4; i++) tx_bytes.push_back(pay[8*i +: 8]);
      for (int i = 0; i < total - 22; i++) tx_bytes.push_back(8'(i * 7 + 3));
      crc = 32'hFFFFFFFF;
      foreach (tx_bytes[i]) begin
         crc = crc ^ {24'h0, tx_bytes[i]};
         for (int j = 0; j < 8; j++) begin
            crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
         end
      end
      crc = ~crc;
      for (int i = 0; i < 4; i++) tx_bytes.push_back(crc[8*i +: 8]);
   endtask

   task automatic drive(input logic [1:0] d, input logic r);
      @(negedge clk);
      rx_dv = 1'b1;
      rx    = d;
      rst_n = r;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_dv = 1'b0;
         rx    = 2'b00;
         rst_n = 1'b1;
      end
   endtask

   task automatic send_frame(input int pre, input int extra, input int rst_at, input bit hold_dv);
      logic [7:0] bt;
      for (int i = 0; i < pre; i++) drive(2'b01, 1'b1);
      drive(2'b11, 1'b1);
      for (int b = 0; b < tx_bytes.size(); b++) begin
         bt = tx_bytes[b];
         for (int k = 0; k < 4; k++) drive(bt[2*k +: 2], !(b == rst_at && k == 0));
      end
      for (int i = 0; i < extra; i++) drive(2'b10, 1'b1);
      if (!hold_dv) idle(4);
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("pulse_timeout", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (valid || frame_drop) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 64'({valid, frame_drop}), 64'd0);
         end else begin
            e = sb.pop_front();
            check("valid", 64'(valid), 64'(!e.is_drop));
            check("frame_drop", 64'(frame_drop), 64'(e.is_drop));
            check("data", 64'(data), 64'(e.d));
            check("src_mac", 64'(src_mac), 64'(e.s));
            check("ethertype", 64'(ethertype), 64'(e.t));
         end
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      rx_dv = 1'b1;
      rx    = 2'b01;
      repeat (4) @(negedge clk);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_frame_drop", 64'(frame_drop), 64'd0);
      check("rst_data", 64'(data), 64'd0);
      check("rst_src_mac", 64'(src_mac), 64'd0);
      check("rst_ethertype", 64'(ethertype), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // rx_dv never low since reset: the frame must be ignored
      build_frame(OWN, 48'h0011_2233_4455, 16'h0800, 32'h01020304, 64);
      send_frame(31, 0, -1, 1'b1);
      @(negedge clk);
      check("no_lock_busy", 64'(busy), 64'd0);
      idle(4);

      // broadcast frame, 64 bytes, good FCS
      push_accept(32'hDEADBEEF, 48'he86a64e7e830, 16'h0400);
      build_frame(BCAST, 48'he86a64e7e830, 16'h0400, 32'hDEADBEEF, 64);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // foreign destination: drop after byte 5, outputs hold
      push_drop();
      build_frame(OTHER, 48'he86a64e7e830, 16'h0400, 32'hDEADBEEF, 64);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // own destination, minimum preamble of 4
      push_accept(32'h12345678, 48'h0011_2233_4455, 16'h0800);
      build_frame(OWN, 48'h0011_2233_4455, 16'h0800, 32'h12345678, 80);
      send_frame(4, 0, -1, 1'b0);
      wait_drain();

      // one payload bit flipped outside the captured bytes
`ifdef RX_FCS_CHECK_EN
      push_drop();
`else
      push_accept(32'hCAFEF00D, 48'h0a0b_0c0d_0e0f, 16'h86DD);
`endif
      build_frame(OWN, 48'h0a0b_0c0d_0e0f, 16'h86DD, 32'hCAFEF00D, 80);
      tx_bytes[40] = tx_bytes[40] ^ 8'h04;
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // runt 60 bytes
      push_drop();
      build_frame(BCAST, 48'h1111_2222_3333, 16'h0800, 32'h55667788, 60);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // 64 bytes ending one dibit late
      push_drop();
      build_frame(BCAST, 48'h1111_2222_3333, 16'h0800, 32'h55667788, 64);
      send_frame(31, 1, -1, 1'b0);
      wait_drain();

      // short preamble: silent drop, busy until rx_dv falls
      build_frame(BCAST, 48'h1111_2222_3333, 16'h0800, 32'h55667788, 64);
      send_frame(3, 0, -1, 1'b1);
      @(negedge clk);
      check("short_pre_busy", 64'(busy), 64'd1);
      idle(2);
      check("short_pre_idle", 64'(busy), 64'd0);

      // oversize 1600-byte frame
      push_drop();
      build_frame(BCAST, 48'h1111_2222_3333, 16'h0800, 32'h55667788, 1600);
      send_frame(31, 0, -1, 1'b1);
      @(negedge clk);
      check("oversize_busy", 64'(busy), 64'd1);
      idle(2);
      check("oversize_idle", 64'(busy), 64'd0);
      wait_drain();

      // maximum 1518-byte frame accepted
      push_accept(32'h0BADF00D, 48'h0066_7788_99aa, 16'h88B5);
      build_frame(BCAST, 48'h0066_7788_99aa, 16'h88B5, 32'h0BADF00D, 1518);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // back-to-back frames with a single idle cycle
      push_accept(32'hA5A5_5A5A, 48'h0001_0203_0405, 16'h0101);
      push_accept(32'h8765_4321, 48'h0006_0708_090a, 16'h0202);
      build_frame(OWN, 48'h0001_0203_0405, 16'h0101, 32'hA5A5_5A5A, 64);
      send_frame(31, 0, -1, 1'b1);
      idle(1);
      build_frame(BCAST, 48'h0006_0708_090a, 16'h0202, 32'h8765_4321, 70);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      // reset pulse mid-payload with rx_dv held
      build_frame(OWN, 48'h0f0e_0d0c_0b0a, 16'h0303, 32'h1357_9BDF, 64);
      send_frame(31, 0, 20, 1'b1);
      @(negedge clk);
      check("rst_mid_busy", 64'(busy), 64'd0);
      idle(4);
      check("rst_mid_data", 64'(data), 64'd0);
      check("rst_mid_src_mac", 64'(src_mac), 64'd0);
      check("rst_mid_ethertype", 64'(ethertype), 64'd0);
      m_data = 32'd0; m_src = 48'd0; m_type = 16'd0;

      push_accept(32'h2468_ACE0, 48'h0f0e_0d0c_0b0a, 16'h0303);
      build_frame(OWN, 48'h0f0e_0d0c_0b0a, 16'h0303, 32'h2468_ACE0, 64);
      send_frame(31, 0, -1, 1'b0);
      wait_drain();

      idle(4);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
